// File: rtl/alu_exec_unit.sv
// Handshaked integer execute unit: single-cycle ALU ops plus an optional
// iterative shift-add multiplier, result held until the consumer takes it.
module alu_exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned EN_MUL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUop,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [SW-1:0] LAST = SW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_t;

  state_t          state;
  op_t             op_dec;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [SW-1:0]   cnt;

  assign in_ready = (state == IDLE);
  assign zero     = (result == '0);
  assign shamt    = op_b[SW-1:0];
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    op_dec = OP_ILL;
    case (ALUop)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        case ({funct7, funct3})
          10'b0000000_000: op_dec = OP_ADD;
          10'b0100000_000: op_dec = OP_SUB;
          10'b0000000_111: op_dec = OP_AND;
          10'b0000000_110: op_dec = OP_OR;
          10'b0000000_100: op_dec = OP_XOR;
          10'b0000000_010: op_dec = OP_SLT;
          10'b0000000_011: op_dec = OP_SLTU;
          10'b0000000_001: op_dec = OP_SLL;
          10'b0000000_101: op_dec = OP_SRL;
          10'b0100000_101: op_dec = OP_SRA;
          10'b0000001_000: op_dec = (EN_MUL != 0) ? OP_MUL : OP_ILL;
          default:         op_dec = OP_ILL;
        endcase
      end
      default: op_dec = OP_ILL;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op_dec)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op_dec == OP_MUL) begin
              mcand  <= op_a;
              mplier <= op_b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              result    <= alu_res;
              illegal   <= (op_dec == OP_ILL);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          // final iteration writes acc_next straight into result so DONE is reached after XLEN cycles
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            result    <= acc_next;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a 32-bit unit with MUL and a second
// instance built without MUL.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUop;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] result2;
  logic        zero2;
  logic        illegal2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_exec_unit #(.XLEN(32), .EN_MUL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .EN_MUL(0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .ALUop(ALUop), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .zero(zero2), .illegal(illegal2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    int unsigned w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    ALUop    = aop;
    funct7   = f7;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ALUop    = 2'($urandom_range(0, 3));
    funct7   = 7'($urandom);
    funct3   = 3'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    check("retire_busy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_idle", 64'(in_ready), 64'd1);
    check("retire_nvalid", 64'(out_valid), 64'd0);
  endtask

  task automatic single(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_ill);
    issue(aop, f7, f3, a, b);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(exp));
    check({tag, "_zero"}, 64'(zero), 64'(exp == 32'd0));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    retire();
  endtask

  initial begin
    int unsigned cyc;
    int unsigned low_cnt;
    int unsigned seen;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    ALUop      = 2'b00;
    funct7     = '0;
    funct3     = '0;
    op_a       = '0;
    op_b       = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_valid2", 64'(out_valid2), 64'd0);
    rst_n = 1'b1;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_ready2", 64'(in_ready2), 64'd1);

    single("sub_eq",   2'b10, 7'b0100000, 3'b000, 32'd5, 32'd5, 32'd0, 1'b0);
    single("add_ld",   2'b00, 7'b1111111, 3'b111, 32'd7, 32'd8, 32'd15, 1'b0);
    single("sub_br",   2'b01, 7'b0000001, 3'b101, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    single("add_ovf",  2'b10, 7'b0000000, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("sra",      2'b10, 7'b0100000, 3'b101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0);
    single("srl",      2'b10, 7'b0000000, 3'b101, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0);
    single("slt",      2'b10, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    single("sltu",     2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    single("and",      2'b10, 7'b0000000, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    single("or",       2'b10, 7'b0000000, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    single("xor",      2'b10, 7'b0000000, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    single("sll",      2'b10, 7'b0000000, 3'b001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0);
    single("ill_op11", 2'b11, 7'b0000000, 3'b000, 32'd9, 32'd9, 32'd0, 1'b1);
    single("ill_f7",   2'b10, 7'b0100000, 3'b111, 32'd9, 32'd9, 32'd0, 1'b1);
    single("after_ill",2'b00, 7'b0000000, 3'b000, 32'd1, 32'd1, 32'd2, 1'b0);

    // MUL: count cycles from acceptance to out_valid, with the consumer stalled
    issue(2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'd3);
    cyc     = 1;
    low_cnt = 0;
    while (!out_valid && cyc < 100) begin
      if (!in_ready) low_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!in_ready) low_cnt++;
    check("mul_cycle", 64'(cyc), 64'd33);
    check("mul_ready_low", 64'(low_cnt), 64'd33);
    check("mul_result", 64'(result), 64'hFFFF_FFFD);
    check("mul_illegal", 64'(illegal), 64'd0);
    retire();

    // stall in DONE while a competing request is presented
    issue(2'b00, 7'b0000000, 3'b000, 32'h1234_5678, 32'd1);
    ALUop    = 2'b00;
    op_a     = 32'd1;
    op_b     = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(result), 64'h1234_5679);
      check("hold_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    retire();
    check("hold_kept", 64'(result), 64'h1234_5679);

    // reset during MUL iteration 12
    issue(2'b10, 7'b0000001, 3'b000, 32'h0001_0001, 32'h0000_FFFF);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_zero", 64'(zero), 64'd1);
    check("arst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("arst_rel_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("arst_no_done", 64'(seen), 64'd0);
    single("arst_add", 2'b00, 7'b0000000, 3'b000, 32'd2, 32'd3, 32'd5, 1'b0);

    // MUL on the instance built without a multiplier
    ALUop     = 2'b10;
    funct7    = 7'b0000001;
    funct3    = 3'b000;
    op_a      = 32'hFFFF_FFFF;
    op_b      = 32'd3;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("nomul_valid", 64'(out_valid2), 64'd1);
    check("nomul_illegal", 64'(illegal2), 64'd1);
    check("nomul_result", 64'(result2), 64'd0);
    check("nomul_zero", 64'(zero2), 64'd1);
    check("nomul_dut1_idle", 64'(out_valid), 64'd0);
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("nomul_retire", 64'(in_ready2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
